// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states, byte width and
// the default transmitter acknowledge timeout.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int DEFAULT_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

  // Advance a requester index by one, wrapping explicitly at n-1 so that a
  // non-power-of-two requester count never reaches an absent index.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from ptr,
// wrapping at NUM_REQ-1 back to 0.
module rr_pick #(
  parameter int  NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     idx,
  output logic               valid
);

  logic [IDW:0] cand;

  // Walk candidates from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IDW + 1)'(k);
      if (cand >= (IDW + 1)'(NUM_REQ)) cand = cand - (IDW + 1)'(NUM_REQ);
      if (req[cand[IDW-1:0]]) begin
        gnt                 = '0;
        gnt[cand[IDW-1:0]]  = 1'b1;
        idx                 = cand[IDW-1:0];
        valid               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte producers.
// Define UART_TX_ARB_TIMEOUT_EN to abort launches the transmitter never acknowledges.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  parameter int  DATA_W  = UART_DATA_W,
  parameter int  TIMEOUT = DEFAULT_TIMEOUT,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic                      arb_busy,
  output logic [IDW-1:0]            cur_id
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
  end

  arb_state_t         state;
  logic [IDW-1:0]     ptr;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDW-1:0]     pick_idx;
  logic               pick_valid;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req  (req),
    .ptr  (ptr),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .valid(pick_valid)
  );

  assign arb_busy = (state != IDLE);

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT + 1);
  logic [TOW-1:0] to_cnt;
  logic           err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Pulse outputs default low each cycle; a reset mid-frame simply drops the sequence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt      <= '0;
      done     <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      cur_id   <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_cnt   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      gnt      <= '0;
      done     <= '0;
      tx_start <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_valid) begin
            tx_data  <= req_data[pick_idx*DATA_W +: DATA_W];
            cur_id   <= pick_idx;
            gnt      <= pick_gnt;
            tx_start <= 1'b1;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          ptr   <= IDW'(wrap_inc(int'(cur_id), NUM_REQ));
          state <= WAIT_BUSY;
`ifdef UART_TX_ARB_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (to_cnt == TOW'(TIMEOUT - 1)) begin
            err_q        <= 1'b1;
            done[cur_id] <= 1'b1;
            state        <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            done[cur_id] <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares the single UART transmitter (start/data_in/out_tx datapath) between NUM_REQ byte producers.
- Accepts one byte per grant from a requester and drives a one-cycle tx_start with tx_data.
- Tracks the transmitter's busy window and returns a per-requester done pulse.
- Sits between the producers and the UART TX top; the only block allowed to drive the transmitter's start and data inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width, equal to UART data_in width.
- TIMEOUT, 64, cycles to wait for tx_busy to rise after tx_start; used only with the optional feature.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester level request; held until the matching gnt.
- req_data  input  NUM_REQ*DATA_W  packed bytes; slice i belongs to req[i] and is stable while req[i]=1.
- gnt  output  NUM_REQ  one-hot, one-cycle pulse; byte i is captured in this cycle.
- done  output  NUM_REQ  one-hot, one-cycle pulse when byte i has finished transmitting.
- err  output  1  one-cycle pulse on transmitter timeout; constant 0 without the feature.
- tx_start  output  1  one-cycle start pulse to the UART TX.
- tx_data  output  DATA_W  byte to the UART TX; valid while tx_start=1 and held until the next launch.
- tx_busy  input  1  high while the UART TX is shifting a frame.
- arb_busy  output  1  high in every state except IDLE.
- cur_id  output  $clog2(NUM_REQ)  index of the owner of the current or last grant.

Behaviour:
- Reset (rst=0, asynchronous):
  - State is IDLE.
  - gnt, done, err, tx_start are 0.
  - tx_data and cur_id are 0.
  - arb_busy is 0.
  - Round-robin pointer is 0, so requester 0 has top priority.
- Reset mid-frame aborts the sequence without a done pulse. The transmitter's own reset is responsible for the line.
- States are IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
- IDLE:
  - If any req bit is 1, the winner is the first set bit searching upward from ptr, wrapping at NUM_REQ-1 back to 0.
  - On that edge: latch req_data slice into tx_data, set cur_id to the winner, set gnt one-hot, go to LAUNCH.
- LAUNCH:
  - gnt and tx_start are both high for exactly this one cycle.
  - Next state is WAIT_BUSY; ptr becomes winner+1 modulo NUM_REQ.
- WAIT_BUSY:
  - Wait for tx_busy=1, then go to WAIT_DONE.
  - If tx_busy is already 1 in the LAUNCH cycle, it still passes through WAIT_BUSY for one cycle.
- WAIT_DONE:
  - On the cycle tx_busy is sampled 0, done[cur_id] pulses for one cycle and the state returns to IDLE.
- Latency from req sampled in IDLE:
  - gnt and tx_start appear the next cycle.
  - Minimum spacing between two tx_start pulses is transmitter frame time + 3 cycles.
- Boundary rules:
  - A req dropped before its grant is legal and is simply not served.
  - A req that stays high after gnt is treated as a new byte request.
  - Simultaneous requests are resolved strictly by the rotating pointer; no requester is granted twice while another is continuously requesting.
  - Requests arriving outside IDLE are ignored until IDLE. They are not queued beyond the req level.
  - With NUM_REQ a non-power of two, the pointer wrap is explicit and never indexes an absent requester.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in WAIT_BUSY.
  - If tx_busy stays 0 for TIMEOUT cycles, err pulses one cycle together with done[cur_id], and the state returns to IDLE.
  - The counter clears on every entry to WAIT_BUSY.
- Without the macro:
  - WAIT_BUSY waits indefinitely.
  - err is tied to 0 and no counter logic is present.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE);
  - the UART_DATA_W=8 constant;
  - the default TIMEOUT constant.
- One natural sub-module, rr_pick. It is combinational and takes req and ptr, returning a one-hot grant, the winner index and a valid flag. This keeps the wrap logic independently testable.
- The state machine, capture registers and counter stay in uart_tx_arbiter.

Test Plan:
- Reset/idle: hold rst=0 20 cycles with req=4'b1111 -> gnt, done, tx_start, err all 0; cur_id=0; arb_busy=0.
- Single byte: req=4'b0100, slice2=8'hAA, model busy high 10 cycles starting 2 cycles after tx_start:
  - gnt=4'b0100 and tx_start=1 in the same cycle, tx_data=8'hAA;
  - done=4'b0100 exactly one cycle after busy falls.
- Fairness: req=4'b1111 held with bytes 8'h10, 8'h11, 8'h12, 8'h13 -> grant order 0,1,2,3,0; tx_data sequence 10,11,12,13,10.
- Wrap/skip: after serving requester 3, req=4'b1001 -> requester 0 granted next; then with req=4'b1001 still held, requester 3.
- Reset mid-frame: assert rst=0 during WAIT_DONE -> all outputs 0 immediately; no done pulse; next req=4'b0010 after release is granted with ptr restarted at 0.
- Timeout (macro on, TIMEOUT=64): tx_busy held 0 after tx_start -> err and done[cur_id] pulse 64 cycles after WAIT_BUSY entry, then IDLE; with macro off -> arb_busy stays 1 and err stays 0.
